spi_frame_rx: RTL and testbench

SPI slave receive front-end for the adaptive-filter top level. It samples the external `sck`/`mosi`/`cs` pins in the `clk` domain and deframes the 14-bit, MSB-first words. It recognises the three-word sequence (header 0x0FFF, sample x, sample d). It presents each completed (x, d) pair to the 32-order adaptive filter core with a one-cycle valid strobe. `miso` is not driven by this block.

---
 rtl/spi_frame_rx.sv | 151 +++++++++++++++
 tb/tb_spi_frame_rx.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_frame_rx.sv
// SPI slave receive front-end: synchronises sck/mosi/cs into clk, deframes 14-bit MSB-first
// words and delivers each {header, x, d} frame as an (x, d) pair with a one-cycle strobe.
module spi_frame_rx #(
  parameter int unsigned    W           = 14,
  parameter logic [W-1:0]   HDR         = 14'h0FFF,
  parameter int unsigned    TIMEOUT_CYC = 1024
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         sck,
  input  logic         mosi,
  input  logic         cs,
  output logic [W-1:0] x_out,
  output logic [W-1:0] d_out,
  output logic         sample_valid,
  output logic         frame_err,
  output logic [15:0]  pair_cnt
);

  localparam int unsigned CntW = $clog2(W + 2);
  localparam int unsigned GapW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CntW-1:0] CntFull = CntW'(W);
  localparam logic [CntW-1:0] CntSat  = CntW'(W + 1);
  localparam logic [GapW-1:0] GapLast = GapW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {StIdle, StHdrOk, StXOk} state_e;

  // Synchroniser chains: bit 0 = s1, bit 1 = s2, bit 2 = s3 (edge-detect history).
  logic [2:0]      sck_sync_q, sck_sync_d;
  logic [1:0]      mosi_sync_q, mosi_sync_d;
  logic [2:0]      cs_sync_q, cs_sync_d;
  logic [W-1:0]    shreg_q, shreg_d;
  logic [CntW-1:0] bit_cnt_q, bit_cnt_d;
  logic [GapW-1:0] gap_cnt_q, gap_cnt_d;
  state_e          state_q, state_d;
  logic [W-1:0]    x_hold_q, x_hold_d;
  logic [W-1:0]    x_out_q, x_out_d;
  logic [W-1:0]    d_out_q, d_out_d;
  logic            sample_valid_q, sample_valid_d;
  logic            frame_err_q, frame_err_d;
  logic [15:0]     pair_cnt_q, pair_cnt_d;

  logic sck_rise, cs_high, cs_rise;

  assign sck_rise = sck_sync_q[1] & ~sck_sync_q[2];
  assign cs_high  = cs_sync_q[1];
  assign cs_rise  = cs_sync_q[1] & ~cs_sync_q[2];

  always_comb begin
    sck_sync_d     = {sck_sync_q[1:0], sck};
    mosi_sync_d    = {mosi_sync_q[0], mosi};
    cs_sync_d      = {cs_sync_q[1:0], cs};
    shreg_d        = shreg_q;
    bit_cnt_d      = bit_cnt_q;
    gap_cnt_d      = gap_cnt_q;
    state_d        = state_q;
    x_hold_d       = x_hold_q;
    x_out_d        = x_out_q;
    d_out_d        = d_out_q;
    sample_valid_d = 1'b0;
    frame_err_d    = 1'b0;
    pair_cnt_d     = pair_cnt_q;

    if (cs_high) begin
      bit_cnt_d = '0;
    end else if (sck_rise) begin
      shreg_d = {shreg_q[W-2:0], mosi_sync_q[1]};
      if (bit_cnt_q != CntSat) begin
        bit_cnt_d = bit_cnt_q + 1'b1;
      end
    end

    if (state_q == StIdle || !cs_high) begin
      gap_cnt_d = '0;
    end else begin
      gap_cnt_d = gap_cnt_q + 1'b1;
    end

    // A word ending wins over a timeout landing in the same cycle.
    if (cs_rise) begin
      if (bit_cnt_q != CntFull) begin
        frame_err_d = 1'b1;
        state_d     = StIdle;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (shreg_q == HDR) begin
              state_d = StHdrOk;
            end else begin
              frame_err_d = 1'b1;
            end
          end
          StHdrOk: begin
            x_hold_d = shreg_q;
            state_d  = StXOk;
          end
          StXOk: begin
            x_out_d        = x_hold_q;
            d_out_d        = shreg_q;
            sample_valid_d = 1'b1;
            pair_cnt_d     = pair_cnt_q + 16'd1;
            state_d        = StIdle;
          end
          default: state_d = StIdle;
        endcase
      end
    end else if (state_q != StIdle && cs_high && gap_cnt_q == GapLast) begin
      frame_err_d = 1'b1;
      state_d     = StIdle;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      sck_sync_q     <= '0;
      mosi_sync_q    <= '0;
      cs_sync_q      <= '0;
      shreg_q        <= '0;
      bit_cnt_q      <= '0;
      gap_cnt_q      <= '0;
      state_q        <= StIdle;
      x_hold_q       <= '0;
      x_out_q        <= '0;
      d_out_q        <= '0;
      sample_valid_q <= 1'b0;
      frame_err_q    <= 1'b0;
      pair_cnt_q     <= '0;
    end else begin
      sck_sync_q     <= sck_sync_d;
      mosi_sync_q    <= mosi_sync_d;
      cs_sync_q      <= cs_sync_d;
      shreg_q        <= shreg_d;
      bit_cnt_q      <= bit_cnt_d;
      gap_cnt_q      <= gap_cnt_d;
      state_q        <= state_d;
      x_hold_q       <= x_hold_d;
      x_out_q        <= x_out_d;
      d_out_q        <= d_out_d;
      sample_valid_q <= sample_valid_d;
      frame_err_q    <= frame_err_d;
      pair_cnt_q     <= pair_cnt_d;
    end
  end

  assign x_out        = x_out_q;
  assign d_out        = d_out_q;
  assign sample_valid = sample_valid_q;
  assign frame_err    = frame_err_q;
  assign pair_cnt     = pair_cnt_q;

endmodule

// File: tb/tb_spi_frame_rx.sv
// Bench for spi_frame_rx: randomised SPI pin timing against a word-level frame model whose
// expected pulses are queued in order and matched by a per-cycle compare process.
module tb_spi_frame_rx;

  localparam int unsigned W   = 14;
  localparam int unsigned TO  = 1024;
  localparam logic [13:0] HDR = 14'h0FFF;

  logic        clk  = 1'b0;
  logic        rstn = 1'b0;
  logic        sck  = 1'b0;
  logic        mosi = 1'b0;
  logic        cs   = 1'b0;
  logic [13:0] x_out, d_out;
  logic        sample_valid, frame_err;
  logic [15:0] pair_cnt;

  spi_frame_rx #(.W(W), .HDR(HDR), .TIMEOUT_CYC(TO)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .sck          (sck),
    .mosi         (mosi),
    .cs           (cs),
    .x_out        (x_out),
    .d_out        (d_out),
    .sample_valid (sample_valid),
    .frame_err    (frame_err),
    .pair_cnt     (pair_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        is_pair;
    logic [13:0] x;
    logic [13:0] d;
  } ev_t;

  ev_t         exp_q[$];
  ev_t         cmp_e;
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          frame_pos = 0;
  logic [13:0] x_pend = '0;
  logic [13:0] mx = '0;
  logic [13:0] md = '0;
  logic [15:0] mcnt = '0;
  int          n_valid = 0;
  int          n_err = 0;
  int          last_err_cyc = 0;
  int          t_csrise = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Word-level frame model: a frame is HDR, x, d; anything else is an error pulse.
  task automatic model_word(input logic [13:0] v, input int nbits);
    if (nbits != int'(W)) begin
      exp_q.push_back({1'b0, 14'h0, 14'h0});
      frame_pos = 0;
    end else if (frame_pos == 0) begin
      if (v == HDR) frame_pos = 1;
      else exp_q.push_back({1'b0, 14'h0, 14'h0});
    end else if (frame_pos == 1) begin
      x_pend    = v;
      frame_pos = 2;
    end else begin
      exp_q.push_back({1'b1, x_pend, v});
      frame_pos = 0;
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic int rgap();
    if ($urandom_range(0, 7) == 0) return int'($urandom_range(300, 320));
    return int'($urandom_range(4, 30));
  endfunction

  task automatic send_bits(input logic [13:0] v, input int nbits);
    @(negedge clk);
    cs = 1'b0;
    wait_cyc(3 + int'($urandom_range(0, 3)));
    for (int i = 0; i < nbits; i++) begin
      mosi = (i < int'(W)) ? v[W-1-i] : 1'b0;
      wait_cyc(int'($urandom_range(3, 5)));
      sck = 1'b1;
      wait_cyc(int'($urandom_range(3, 5)));
      sck = 1'b0;
    end
    wait_cyc(int'($urandom_range(3, 5)));
  endtask

  task automatic send_word(input logic [13:0] v, input int nbits, input int gap);
    send_bits(v, nbits);
    cs       = 1'b1;
    t_csrise = cyc;
    model_word(v, nbits);
    if (gap > int'(TO) + 16 && frame_pos != 0) begin
      exp_q.push_back({1'b0, 14'h0, 14'h0});
      frame_pos = 0;
    end
    wait_cyc(gap);
  endtask

  task automatic send_frame(input logic [13:0] xv, input logic [13:0] dv);
    send_word(HDR, W, rgap());
    send_word(xv, W, rgap());
    send_word(dv, W, rgap());
  endtask

  task automatic drain(input string name);
    wait_cyc(20);
    chk(name, exp_q.size(), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    cs   = 1'b0;
    sck  = 1'b0;
    mosi = 1'b0;
    rstn = 1'b0;
    frame_pos = 0;
    wait_cyc(2);
    rstn = 1'b1;
    wait_cyc(3);
  endtask

  // Compare process: match every pulse against the queued expectation, check outputs each cycle.
  always @(posedge clk) begin
    #1;
    cyc++;
    if (!rstn) begin
      mx   = '0;
      md   = '0;
      mcnt = '0;
      chk("valid_in_reset", sample_valid, 0);
      chk("err_in_reset", frame_err, 0);
    end else begin
      if (sample_valid) begin
        n_valid++;
        if (exp_q.size() == 0) begin
          chk("unexpected_valid", 1, 0);
        end else begin
          cmp_e = exp_q.pop_front();
          chk("valid_kind", cmp_e.is_pair, 1);
          if (cmp_e.is_pair) begin
            mx   = cmp_e.x;
            md   = cmp_e.d;
            mcnt = mcnt + 16'd1;
          end
        end
      end
      if (frame_err) begin
        n_err++;
        last_err_cyc = cyc;
        if (exp_q.size() == 0) begin
          chk("unexpected_err", 1, 0);
        end else begin
          cmp_e = exp_q.pop_front();
          chk("err_kind", cmp_e.is_pair, 0);
        end
      end
    end
    chk("x_out", x_out, mx);
    chk("d_out", d_out, md);
    chk("pair_cnt", pair_cnt, mcnt);
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int nb;
    logic [13:0] v;

    // Basic frame at nominal-style gaps.
    do_reset();
    chk("rst_x", x_out, 0);
    chk("rst_d", d_out, 0);
    chk("rst_cnt", pair_cnt, 0);
    n_valid = 0;
    n_err   = 0;
    send_word(HDR, W, 50);
    send_word(14'h054B, W, 310);
    send_word(14'h054C, W, 50);
    drain("pending_basic");
    chk("basic_x", x_out, 14'h054B);
    chk("basic_d", d_out, 14'h054C);
    chk("basic_cnt", pair_cnt, 1);
    chk("basic_nvalid", n_valid, 1);
    chk("basic_nerr", n_err, 0);

    // Sweep of 70 frames.
    do_reset();
    n_valid = 0;
    for (int k = 0; k < 70; k++) begin
      v = 14'(1355 + 10 * k);
      send_frame(v, v + 14'd1);
    end
    drain("pending_sweep");
    chk("sweep_cnt", pair_cnt, 70);
    chk("sweep_nvalid", n_valid, 70);
    chk("sweep_x", x_out, 14'd2045);
    chk("sweep_d", d_out, 14'd2046);

    // Bad header: every word rejected in idle, outputs untouched.
    n_valid = 0;
    n_err   = 0;
    send_word(14'h1234, W, rgap());
    send_word(14'h0100, W, rgap());
    send_word(14'h0200, W, rgap());
    drain("pending_badhdr");
    chk("badhdr_nerr", n_err, 3);
    chk("badhdr_nvalid", n_valid, 0);
    chk("badhdr_x", x_out, 14'd2045);

    // Short word aborts the frame; header value is a legal sample.
    n_err = 0;
    send_word(HDR, W, rgap());
    send_word(14'h0ABC, 10, rgap());
    send_word(HDR, W, rgap());
    send_word(HDR, W, rgap());
    send_word(14'h0001, W, rgap());
    drain("pending_short");
    chk("short_nerr", n_err, 1);
    chk("short_x", x_out, 14'h0FFF);
    chk("short_d", d_out, 14'h0001);

    // Mid-frame timeout.
    n_err = 0;
    send_word(HDR, W, 10);
    send_word(14'h0333, W, 1100);
    chk("timeout_seen", n_err, 1);
    chk("timeout_cycle", ((last_err_cyc - t_csrise) >= int'(TO)) &&
                         ((last_err_cyc - t_csrise) <= int'(TO) + 10), 1);
    send_word(14'h0444, W, 10);
    send_word(HDR, W, 10);
    send_word(14'h0555, W, 10);
    send_word(14'h0666, W, 10);
    drain("pending_timeout");
    chk("timeout_nerr", n_err, 2);
    chk("after_to_x", x_out, 14'h0555);
    chk("after_to_d", d_out, 14'h0666);

    // Random words: mixed headers, random data, occasional wrong lengths.
    for (int k = 0; k < 60; k++) begin
      v  = ($urandom_range(0, 2) == 0) ? HDR : 14'($urandom);
      nb = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, W + 2)) : int'(W);
      send_word(v, nb, rgap());
    end
    drain("pending_random");

    // Reset in the middle of an x word.
    do_reset();
    send_frame(14'h0111, 14'h0222);
    send_word(HDR, W, 10);
    send_bits(14'h0ABC, 6);
    rstn      = 1'b0;
    frame_pos = 0;
    wait_cyc(2);
    rstn = 1'b1;
    wait_cyc(3);
    chk("midrst_x", x_out, 0);
    chk("midrst_d", d_out, 0);
    chk("midrst_cnt", pair_cnt, 0);
    cs = 1'b1;
    model_word(14'h0, 0);
    wait_cyc(10);
    send_frame(14'h0AAA, 14'h0555);
    drain("pending_midrst");
    chk("midrst_pair_cnt", pair_cnt, 1);
    chk("midrst_pair_x", x_out, 14'h0AAA);
    chk("midrst_pair_d", d_out, 14'h0555);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
